vga_sync_decoder: RTL
=====================

# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: takes a raw hsync/vsync stream (1024x768 timing, 65 MHz pixel clock domain) and reconstructs hcount/vcount/hblnk/vblnk aligned to the incoming sync. It locks onto the stream, verifies it against the configured timing, and flags deviations. Used on the loop-back path and in self-check benches, downstream of any module that drives VGA sync.

## Interface
- H_ADDR_TIME, 1024, visible pixels per line
- H_SYNC_START, 1048, hcount at hsync rising edge (addr + front porch)
- H_TOTAL_TIME, 1344, clocks per line
- V_ADDR_TIME, 768, visible lines per frame
- V_SYNC_START, 771, vcount at vsync rising edge
- V_TOTAL_TIME, 806, lines per frame
- LOCK_FRAMES, 2, clean frames required in VERIFY before LOCKED (1..15)

- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hsync_in  in  1  incoming hsync, active high, same clock domain
- vsync_in  in  1  incoming vsync, active high, same clock domain
- hcount  out  11  recovered pixel column
- vcount  out  11  recovered line
- hblnk  out  1  hcount >= H_ADDR_TIME
- vblnk  out  1  vcount >= V_ADDR_TIME
- hsync_out, vsync_out  out  1 each  inputs delayed 2 clk, aligned with counts
- locked  out  1  high in LOCKED state
- frame_start  out  1  one-clk pulse when locked and hcount==0, vcount==0
- err  out  1  one-clk pulse on timing mismatch while LOCKED
- err_count  out  8  saturating mismatch counter (see Configuration)

## Operation
- Stage 1 registers inputs (hs_q, vs_q) and their previous values; h_edge = hs_q & ~hs_qq, v_edge likewise.
- Stage 2 counters h_cnt/v_cnt (11 bit). Free-run: h_cnt wraps H_TOTAL_TIME-1 -> 0; on wrap v_cnt increments, wrapping V_TOTAL_TIME-1 -> 0.
- Predicted events: h_pred = (h_cnt == H_SYNC_START-1); v_pred = (h_cnt == H_TOTAL_TIME-1) & (v_cnt == V_SYNC_START-1).
- Mismatch = (h_edge XOR h_pred) | (v_edge XOR v_pred); covers early, late and missing edges.
- FSM:
  - SEARCH: on h_edge load h_cnt <= H_SYNC_START -> HLOCK.
  - HLOCK: h mismatch -> SEARCH. v_edge with h_cnt == H_TOTAL_TIME-1: v_cnt <= V_SYNC_START, h_cnt <= 0, good <= 0 -> VERIFY. v_edge elsewhere ignored.
  - VERIFY: any mismatch -> HLOCK (silent, no err). Each predicted v_edge matched: good++; at good == LOCK_FRAMES -> LOCKED.
  - LOCKED: any mismatch -> err pulse, err_count++, -> SEARCH.
- Outputs when not LOCKED: hcount=vcount=0, hblnk=vblnk=1, frame_start=0.
- Simultaneous h_edge and v_edge: counters follow h_edge load; v check fails -> mismatch.
- hblnk/vblnk/frame_start registered from h_cnt/v_cnt, same cycle as hcount/vcount.

## Timing
- Latency: all outputs lag inputs by 2 clk; hcount == H_SYNC_START in the cycle hsync_out first goes high.
- Reset: state SEARCH, counters 0, hcount=vcount=0, hblnk=vblnk=1, hsync_out=vsync_out=0, locked=0, frame_start=0, err=0, err_count=0.
- Reset mid-frame: next clk is reset state; relock requires fresh h_edge, v_edge, then LOCK_FRAMES frames.
- Lock time from clean stream: ≤ 1 line + 1 frame (HLOCK) + LOCK_FRAMES frames.
- err asserted the cycle after the offending sample reaches stage 1; locked drops same cycle as err.
- err_count saturates at 255; cleared only by rst.

## Configuration
- VGA_SYNC_DECODER_ERRCNT_EN defined: err_count counter implemented as above.
- Undefined: counter logic omitted, err_count tied to 8'd0; err pulse unchanged.

## Test plan
- Clean 1024x768 stream from reset -> locked rises after 1+LOCK_FRAMES vsync edges; hcount==1048 when hsync_out rises; frame_start every 1344*806 clk.
- Locked, one hsync rising 1 clk early -> single err pulse, locked=0, err_count=1, state SEARCH; relock after 3 further frames.
- Locked, one hsync edge dropped -> err at predicted edge position (hcount 1047->1048 slot), err_count increments.
- Mismatch during VERIFY (vsync one line late) -> no err, err_count unchanged, locked stays 0 until clean frames follow.
- rst asserted mid-line while locked -> next cycle all outputs at reset values; 300 forced mismatches -> err_count == 255 (0 with macro undefined).

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers hcount/vcount/blanking from an incoming VGA hsync/vsync stream
// Optional feature macro: VGA_SYNC_DECODER_ERRCNT_EN (saturating err_count; tied to 0 when undefined)
module vga_sync_decoder #(
  parameter int H_ADDR_TIME  = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_TOTAL_TIME = 1344,
  parameter int V_ADDR_TIME  = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_TOTAL_TIME = 806,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        locked,
  output logic        frame_start,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [10:0] H_ADDR = 11'(H_ADDR_TIME);
  localparam logic [10:0] H_SYNC = 11'(H_SYNC_START);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL_TIME - 1);
  localparam logic [10:0] V_ADDR = 11'(V_ADDR_TIME);
  localparam logic [10:0] V_SYNC = 11'(V_SYNC_START);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL_TIME - 1);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, HLOCK, VERIFY, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        hs_q, hs_qq, vs_q, vs_qq;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [3:0]  good_q, good_d;
  logic        err_d;
  logic        h_edge, v_edge, h_wrap, h_pred, v_pred, h_mis, v_mis;

  assign h_edge = hs_q & ~hs_qq;
  assign v_edge = vs_q & ~vs_qq;
  assign h_wrap = (h_cnt_q == H_LAST);
  assign h_pred = (h_cnt_q == H_SYNC - 11'd1);
  assign v_pred = h_wrap & (v_cnt_q == V_SYNC - 11'd1);
  assign h_mis  = h_edge ^ h_pred;
  assign v_mis  = v_edge ^ v_pred;

  // Counters free-run in every state; only SEARCH and HLOCK re-phase them.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end
    case (state_q)
      SEARCH: begin
        if (h_edge) begin
          h_cnt_d = H_SYNC;
          state_d = HLOCK;
        end
      end
      HLOCK: begin
        if (h_mis) begin
          state_d = SEARCH;
        end else if (v_edge && h_wrap) begin
          h_cnt_d = 11'd0;
          v_cnt_d = V_SYNC;
          good_d  = 4'd0;
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (h_mis || v_mis) begin
          state_d = HLOCK;
        end else if (v_pred) begin
          good_d = good_q + 4'd1;
          if (good_d == LOCK_N) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (h_mis || v_mis) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q        <= 1'b0;
      hs_qq       <= 1'b0;
      vs_q        <= 1'b0;
      vs_qq       <= 1'b0;
      state_q     <= SEARCH;
      h_cnt_q     <= 11'd0;
      v_cnt_q     <= 11'd0;
      good_q      <= 4'd0;
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b1;
      vblnk       <= 1'b1;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      hs_q      <= hsync_in;
      hs_qq     <= hs_q;
      vs_q      <= vsync_in;
      vs_qq     <= vs_q;
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      good_q    <= good_d;
      hsync_out <= hs_q;
      vsync_out <= vs_q;
      err       <= err_d;
      locked    <= (state_d == LOCKED);
      // Outputs come from next-state counters so they share the cycle of hsync_out/vsync_out.
      if (state_d == LOCKED) begin
        hcount      <= h_cnt_d;
        vcount      <= v_cnt_d;
        hblnk       <= (h_cnt_d >= H_ADDR);
        vblnk       <= (v_cnt_d >= V_ADDR);
        frame_start <= (h_cnt_d == 11'd0) && (v_cnt_d == 11'd0);
      end else begin
        hcount      <= 11'd0;
        vcount      <= 11'd0;
        hblnk       <= 1'b1;
        vblnk       <= 1'b1;
        frame_start <= 1'b0;
      end
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
